// File: rtl/mult_share_arbiter_pkg.sv
// Shared FSM encoding and one-hot helper for the multiplier-sharing arbiter.
// Pure declarations, no logic or state.
package mult_share_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam int MAX_R = 32;

  function automatic logic [MAX_R-1:0] onehot(input int idx);
    return MAX_R'(1) << idx;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_pick.sv
// Round-robin pick: first asserted request at or above ptr, wrapping modulo R.
// Purely combinational, zero latency; no backpressure.
module mult_share_arbiter_rr_pick #(
  parameter int R = 4,
  localparam int PW = (R > 1) ? $clog2(R) : 1
) (
  input  logic [R-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] grant,
  output logic          any_req
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    grant = ptr;
    idx   = 0;
    for (int k = R - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= R) idx = idx - R;
      if (req[PW'(idx)]) grant = PW'(idx);
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one sequential multiplier among R requesters with round-robin grant and a watchdog.
// Ack -> start next cycle -> response one cycle after mul_ready; requesters hold req_valid until acked.
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int N       = 4,
  parameter int R       = 4,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [R-1:0]   req_valid,
  input  logic [R*N-1:0] req_a,
  input  logic [R*N-1:0] req_b,
  output logic [R-1:0]   req_ack,
  output logic [R-1:0]   resp_valid,
  output logic [2*N-1:0] resp_product,
  output logic           resp_err,
  output logic           busy,
  output logic           mul_start,
  output logic [N-1:0]   mul_multiplier,
  output logic [N-1:0]   mul_multiplicand,
  input  logic           mul_ready,
  input  logic [2*N-1:0] mul_product
);

  localparam int PW = (R > 1) ? $clog2(R) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t         state_q, state_d;
  logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]  grant_q, grant_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [R-1:0]   req_ack_q, req_ack_d;
  logic [R-1:0]   resp_valid_q, resp_valid_d;
  logic [2*N-1:0] resp_product_q, resp_product_d;
  logic           resp_err_q, resp_err_d;
  logic           busy_q, busy_d;
  logic           mul_start_q, mul_start_d;
  logic [N-1:0]   mul_a_q, mul_a_d;
  logic [N-1:0]   mul_b_q, mul_b_d;

  logic [PW-1:0]  pick;
  logic           any_req;
  logic [PW-1:0]  grant_next;
  logic [N-1:0]   a_arr [R];
  logic [N-1:0]   b_arr [R];

  for (genvar i = 0; i < R; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*N +: N];
    assign b_arr[i] = req_b[i*N +: N];
  end

  mult_share_arbiter_rr_pick #(.R(R)) u_rr_pick (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .grant   (pick),
    .any_req (any_req)
  );

  assign grant_next = (grant_q == PW'(R - 1)) ? '0 : grant_q + PW'(1);

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_d        = grant_q;
    timer_d        = timer_q;
    req_ack_d      = '0;
    resp_valid_d   = '0;
    resp_product_d = resp_product_q;
    resp_err_d     = resp_err_q;
    mul_start_d    = 1'b0;
    mul_a_d        = mul_a_q;
    mul_b_d        = mul_b_q;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d   = pick;
          mul_a_d   = a_arr[pick];
          mul_b_d   = b_arr[pick];
          req_ack_d = R'(onehot(int'(pick)));
          state_d   = ST_START;
        end
      end
      ST_START: begin
        mul_start_d = 1'b1;
        timer_d     = '0;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_q + TW'(1);
        // A ready arriving on the last allowed cycle still counts as a result.
        if (mul_ready) begin
          resp_product_d = mul_product;
          resp_err_d     = 1'b0;
          resp_valid_d   = R'(onehot(int'(grant_q)));
          rr_ptr_d       = grant_next;
          state_d        = ST_IDLE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          resp_product_d = '0;
          resp_err_d     = 1'b1;
          resp_valid_d   = R'(onehot(int'(grant_q)));
          rr_ptr_d       = grant_next;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      rr_ptr_q       <= '0;
      grant_q        <= '0;
      timer_q        <= '0;
      req_ack_q      <= '0;
      resp_valid_q   <= '0;
      resp_product_q <= '0;
      resp_err_q     <= 1'b0;
      busy_q         <= 1'b0;
      mul_start_q    <= 1'b0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_q        <= grant_d;
      timer_q        <= timer_d;
      req_ack_q      <= req_ack_d;
      resp_valid_q   <= resp_valid_d;
      resp_product_q <= resp_product_d;
      resp_err_q     <= resp_err_d;
      busy_q         <= busy_d;
      mul_start_q    <= mul_start_d;
      mul_a_q        <= mul_a_d;
      mul_b_q        <= mul_b_d;
    end
  end

  assign req_ack          = req_ack_q;
  assign resp_valid       = resp_valid_q;
  assign resp_product     = resp_product_q;
  assign resp_err         = resp_err_q;
  assign busy             = busy_q;
  assign mul_start        = mul_start_q;
  assign mul_multiplier   = mul_a_q;
  assign mul_multiplicand = mul_b_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: behavioural multiplier (start->ready N+1 cycles) and a response scoreboard.
module tb_mult_share_arbiter;

  localparam int N       = 4;
  localparam int R       = 4;
  localparam int TIMEOUT = 16;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b1;
  logic [R-1:0]   req_valid = '0;
  logic [R*N-1:0] req_a = '0;
  logic [R*N-1:0] req_b = '0;
  logic [R-1:0]   req_ack;
  logic [R-1:0]   resp_valid;
  logic [2*N-1:0] resp_product;
  logic           resp_err;
  logic           busy;
  logic           mul_start;
  logic [N-1:0]   mul_multiplier;
  logic [N-1:0]   mul_multiplicand;
  logic           mul_ready;
  logic [2*N-1:0] mul_product;

  logic           inj_ready     = 1'b0;
  logic           model_en      = 1'b1;
  logic           model_ready   = 1'b0;
  logic [2*N-1:0] model_product = '0;
  logic [2*N-1:0] pa = '0;
  logic [2*N-1:0] pb = '0;
  int             cnt = 0;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  typedef struct {logic [R-1:0] vld; logic [2*N-1:0] prod; logic err; logic bsy; int cyc;} resp_t;
  typedef struct {logic [R-1:0] ack; logic bsy; int cyc;} ack_t;
  typedef struct {logic [N-1:0] a; logic [N-1:0] b; int cyc;} start_t;
  typedef struct {logic [R-1:0] vld; logic [2*N-1:0] prod; logic err;} exp_t;

  resp_t  resp_log[$];
  ack_t   ack_log[$];
  start_t start_log[$];
  exp_t   exp_q[$];

  assign mul_ready   = model_ready | inj_ready;
  assign mul_product = model_product;

  mult_share_arbiter #(.N(N), .R(R), .TIMEOUT(TIMEOUT)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_a            (req_a),
    .req_b            (req_b),
    .req_ack          (req_ack),
    .resp_valid       (resp_valid),
    .resp_product     (resp_product),
    .resp_err         (resp_err),
    .busy             (busy),
    .mul_start        (mul_start),
    .mul_multiplier   (mul_multiplier),
    .mul_multiplicand (mul_multiplicand),
    .mul_ready        (mul_ready),
    .mul_product      (mul_product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Multiplier model: ready pulse in the (N+1)th cycle after the start cycle.
  always @(posedge clk) begin
    model_ready <= 1'b0;
    if (mul_start && model_en) begin
      cnt <= N;
      pa  <= {{N{1'b0}}, mul_multiplier};
      pb  <= {{N{1'b0}}, mul_multiplicand};
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        model_ready   <= 1'b1;
        model_product <= pa * pb;
      end
    end
  end

  always @(negedge clk) begin
    if (resp_valid != '0) resp_log.push_back('{resp_valid, resp_product, resp_err, busy, cyc});
    if (req_ack != '0)    ack_log.push_back('{req_ack, busy, cyc});
    if (mul_start)        start_log.push_back('{mul_multiplier, mul_multiplicand, cyc});
  end

  task automatic set_ops(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; inj_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int a0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({req_ack, resp_valid, resp_product, resp_err, busy, mul_start, mul_multiplier, mul_multiplicand} !== 27'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs got ack=%b vld=%b prod=%0d err=%b busy=%b start=%b a=%0d b=%0d, want all 0",
               req_ack, resp_valid, resp_product, resp_err, busy, mul_start, mul_multiplier, mul_multiplicand);
    end
    rst_n = 1'b1;
    a0 = ack_log.size();
    repeat (3) @(negedge clk);
    tests_run++;
    if (ack_log.size() != a0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle got acks=%0d busy=%b, want 0 acks busy=0", ack_log.size() - a0, busy);
    end
  endtask

  task automatic test_all_four();
    int a0, r0;
    exp_t e;
    do_reset();
    a0 = ack_log.size(); r0 = resp_log.size();
    set_ops(0, 4'd1, 4'd2);   set_ops(1, 4'd3, 4'd4);
    set_ops(2, 4'd5, 4'd6);   set_ops(3, 4'd15, 4'd15);
    exp_q.push_back('{4'b0001, 8'd2, 1'b0});
    exp_q.push_back('{4'b0010, 8'd12, 1'b0});
    exp_q.push_back('{4'b0100, 8'd30, 1'b0});
    exp_q.push_back('{4'b1000, 8'd225, 1'b0});
    req_valid = 4'b1111;
    for (int c = 0; c < 200 && resp_log.size() < r0 + 4; c++) begin
      @(negedge clk);
      req_valid = req_valid & ~req_ack;
    end
    repeat (4) @(negedge clk);
    tests_run++;
    if (ack_log.size() - a0 != 4 || resp_log.size() - r0 != 4) begin
      tests_failed++;
      $display("FAIL all_four_counts got acks=%0d resps=%0d, want 4/4", ack_log.size() - a0, resp_log.size() - r0);
    end
    for (int i = 0; i < 4 && a0 + i < ack_log.size(); i++) begin
      tests_run++;
      if (ack_log[a0+i].ack !== R'(1 << i) || ack_log[a0+i].bsy !== 1'b1) begin
        tests_failed++;
        $display("FAIL all_four_ack%0d got ack=%b busy=%b, want ack=%b busy=1", i, ack_log[a0+i].ack, ack_log[a0+i].bsy, R'(1 << i));
      end
    end
    for (int i = r0; i < resp_log.size(); i++) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL all_four_extra_resp got vld=%b", resp_log[i].vld);
      end else begin
        e = exp_q.pop_front();
        if ({resp_log[i].vld, resp_log[i].prod, resp_log[i].err, resp_log[i].bsy} !== {e.vld, e.prod, e.err, 1'b0}) begin
          tests_failed++;
          $display("FAIL all_four_resp got vld=%b prod=%0d err=%b busy=%b, want vld=%b prod=%0d err=%b busy=0",
                   resp_log[i].vld, resp_log[i].prod, resp_log[i].err, resp_log[i].bsy, e.vld, e.prod, e.err);
        end
      end
    end
    if (ack_log.size() - a0 == 4 && resp_log.size() - r0 == 4) begin
      tests_run++;
      if (ack_log[a0+1].cyc != resp_log[r0].cyc + 1) begin
        tests_failed++;
        $display("FAIL back_to_back got ack1 at %0d, want %0d", ack_log[a0+1].cyc, resp_log[r0].cyc + 1);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_single();
    int a0, r0, s0;
    exp_t e;
    a0 = ack_log.size(); r0 = resp_log.size(); s0 = start_log.size();
    @(negedge clk);
    set_ops(2, 4'd7, 4'd9);
    exp_q.push_back('{4'b0100, 8'd63, 1'b0});
    req_valid = 4'b0100;
    for (int c = 0; c < 60 && resp_log.size() < r0 + 1; c++) begin
      @(negedge clk);
      req_valid = req_valid & ~req_ack;
    end
    repeat (4) @(negedge clk);
    tests_run++;
    if (ack_log.size() - a0 != 1 || start_log.size() - s0 != 1 || resp_log.size() - r0 != 1) begin
      tests_failed++;
      $display("FAIL single_counts got acks=%0d starts=%0d resps=%0d, want 1/1/1",
               ack_log.size() - a0, start_log.size() - s0, resp_log.size() - r0);
    end
    if (ack_log.size() > a0 && start_log.size() > s0 && resp_log.size() > r0) begin
      tests_run++;
      if (ack_log[a0].ack !== 4'b0100) begin
        tests_failed++;
        $display("FAIL single_ack got %b, want 0100", ack_log[a0].ack);
      end
      tests_run++;
      if ({start_log[s0].a, start_log[s0].b} !== {4'd7, 4'd9} || start_log[s0].cyc != ack_log[a0].cyc + 1) begin
        tests_failed++;
        $display("FAIL single_start got a=%0d b=%0d dt=%0d, want 7/9 dt=1",
                 start_log[s0].a, start_log[s0].b, start_log[s0].cyc - ack_log[a0].cyc);
      end
      tests_run++;
      e = exp_q.pop_front();
      if ({resp_log[r0].vld, resp_log[r0].prod, resp_log[r0].err} !== {e.vld, e.prod, e.err}) begin
        tests_failed++;
        $display("FAIL single_resp got vld=%b prod=%0d err=%b, want vld=%b prod=%0d err=%b",
                 resp_log[r0].vld, resp_log[r0].prod, resp_log[r0].err, e.vld, e.prod, e.err);
      end
      tests_run++;
      if (resp_log[r0].cyc - ack_log[a0].cyc != N + 3) begin
        tests_failed++;
        $display("FAIL single_latency got %0d, want %0d", resp_log[r0].cyc - ack_log[a0].cyc, N + 3);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_fairness();
    int a0, r0, nacks;
    exp_t e;
    do_reset();
    a0 = ack_log.size(); r0 = resp_log.size(); nacks = 0;
    set_ops(0, 4'd2, 4'd3);
    set_ops(3, 4'd4, 4'd5);
    for (int i = 0; i < 6; i++)
      if (i % 2 == 0) exp_q.push_back('{4'b0001, 8'd6, 1'b0});
      else            exp_q.push_back('{4'b1000, 8'd20, 1'b0});
    req_valid = 4'b1001;
    for (int c = 0; c < 300 && resp_log.size() < r0 + 6; c++) begin
      @(negedge clk);
      if (req_ack != '0) nacks++;
      if (nacks >= 6) req_valid = '0;
    end
    req_valid = '0;
    repeat (4) @(negedge clk);
    tests_run++;
    if (ack_log.size() - a0 != 6 || resp_log.size() - r0 != 6) begin
      tests_failed++;
      $display("FAIL fair_counts got acks=%0d resps=%0d, want 6/6", ack_log.size() - a0, resp_log.size() - r0);
    end
    for (int i = 0; i < 6 && a0 + i < ack_log.size(); i++) begin
      tests_run++;
      if (ack_log[a0+i].ack !== ((i % 2 == 0) ? 4'b0001 : 4'b1000)) begin
        tests_failed++;
        $display("FAIL fair_ack%0d got %b, want %b", i, ack_log[a0+i].ack, (i % 2 == 0) ? 4'b0001 : 4'b1000);
      end
    end
    for (int i = r0; i < resp_log.size(); i++) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL fair_extra_resp got vld=%b", resp_log[i].vld);
      end else begin
        e = exp_q.pop_front();
        if ({resp_log[i].vld, resp_log[i].prod, resp_log[i].err} !== {e.vld, e.prod, e.err}) begin
          tests_failed++;
          $display("FAIL fair_resp got vld=%b prod=%0d err=%b, want vld=%b prod=%0d err=%b",
                   resp_log[i].vld, resp_log[i].prod, resp_log[i].err, e.vld, e.prod, e.err);
        end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_timeout();
    int a0, r0;
    exp_t e;
    a0 = ack_log.size(); r0 = resp_log.size();
    @(negedge clk);
    model_en = 1'b0;
    set_ops(1, 4'd5, 4'd5);
    exp_q.push_back('{4'b0010, 8'd0, 1'b1});
    req_valid = 4'b0010;
    for (int c = 0; c < 80 && resp_log.size() < r0 + 1; c++) begin
      @(negedge clk);
      req_valid = req_valid & ~req_ack;
    end
    @(negedge clk);
    model_en = 1'b1;
    tests_run++;
    if (resp_log.size() - r0 != 1 || ack_log.size() - a0 != 1) begin
      tests_failed++;
      $display("FAIL timeout_counts got acks=%0d resps=%0d, want 1/1", ack_log.size() - a0, resp_log.size() - r0);
    end else begin
      tests_run++;
      e = exp_q.pop_front();
      if ({resp_log[r0].vld, resp_log[r0].prod, resp_log[r0].err} !== {e.vld, e.prod, e.err}) begin
        tests_failed++;
        $display("FAIL timeout_resp got vld=%b prod=%0d err=%b, want vld=%b prod=%0d err=%b",
                 resp_log[r0].vld, resp_log[r0].prod, resp_log[r0].err, e.vld, e.prod, e.err);
      end
      tests_run++;
      if (resp_log[r0].cyc - ack_log[a0].cyc != TIMEOUT + 1) begin
        tests_failed++;
        $display("FAIL timeout_latency got %0d, want %0d", resp_log[r0].cyc - ack_log[a0].cyc, TIMEOUT + 1);
      end
    end
    exp_q.delete();
    a0 = ack_log.size(); r0 = resp_log.size();
    set_ops(0, 4'd6, 4'd7);
    set_ops(3, 4'd9, 4'd11);
    exp_q.push_back('{4'b1000, 8'd99, 1'b0});
    exp_q.push_back('{4'b0001, 8'd42, 1'b0});
    req_valid = 4'b1001;
    for (int c = 0; c < 100 && resp_log.size() < r0 + 2; c++) begin
      @(negedge clk);
      req_valid = req_valid & ~req_ack;
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (ack_log.size() <= a0 || ack_log[a0].ack !== 4'b1000) begin
      tests_failed++;
      $display("FAIL timeout_next_grant got %b, want 1000", (ack_log.size() > a0) ? ack_log[a0].ack : 4'b0000);
    end
    for (int i = r0; i < resp_log.size(); i++) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL timeout_extra_resp got vld=%b", resp_log[i].vld);
      end else begin
        e = exp_q.pop_front();
        if ({resp_log[i].vld, resp_log[i].prod, resp_log[i].err} !== {e.vld, e.prod, e.err}) begin
          tests_failed++;
          $display("FAIL timeout_after_resp got vld=%b prod=%0d err=%b, want vld=%b prod=%0d err=%b",
                   resp_log[i].vld, resp_log[i].prod, resp_log[i].err, e.vld, e.prod, e.err);
        end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_wait();
    int a0, r0, s0;
    exp_t e;
    s0 = start_log.size();
    @(negedge clk);
    set_ops(1, 4'd5, 4'd6);
    req_valid = 4'b0010;
    for (int c = 0; c < 30 && start_log.size() < s0 + 1; c++) begin
      @(negedge clk);
      req_valid = req_valid & ~req_ack;
    end
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({req_ack, resp_valid, resp_product, resp_err, busy, mul_start, mul_multiplier, mul_multiplicand} !== 27'd0) begin
      tests_failed++;
      $display("FAIL midwait_reset got ack=%b vld=%b prod=%0d err=%b busy=%b start=%b a=%0d b=%0d, want all 0",
               req_ack, resp_valid, resp_product, resp_err, busy, mul_start, mul_multiplier, mul_multiplicand);
    end
    @(negedge clk);
    rst_n = 1'b1;
    a0 = ack_log.size(); r0 = resp_log.size();
    repeat (10) @(negedge clk);
    tests_run++;
    if (resp_log.size() != r0 || ack_log.size() != a0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL stale_ready got resps=%0d acks=%0d busy=%b, want 0/0/0", resp_log.size() - r0, ack_log.size() - a0, busy);
    end
    set_ops(1, 4'd0, 4'd13);
    exp_q.push_back('{4'b0010, 8'd0, 1'b0});
    req_valid = 4'b0010;
    for (int c = 0; c < 60 && resp_log.size() < r0 + 1; c++) begin
      @(negedge clk);
      req_valid = req_valid & ~req_ack;
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (resp_log.size() - r0 != 1) begin
      tests_failed++;
      $display("FAIL after_reset_count got %0d resps, want 1", resp_log.size() - r0);
    end else begin
      e = exp_q.pop_front();
      if ({resp_log[r0].vld, resp_log[r0].prod, resp_log[r0].err} !== {e.vld, e.prod, e.err}) begin
        tests_failed++;
        $display("FAIL after_reset_resp got vld=%b prod=%0d err=%b, want vld=%b prod=%0d err=%b",
                 resp_log[r0].vld, resp_log[r0].prod, resp_log[r0].err, e.vld, e.prod, e.err);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_ready_outside_wait();
    int a0, r0;
    exp_t e;
    a0 = ack_log.size(); r0 = resp_log.size();
    @(negedge clk);
    inj_ready = 1'b1;
    @(negedge clk);
    inj_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (resp_log.size() != r0 || ack_log.size() != a0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_ready got resps=%0d acks=%0d busy=%b, want 0/0/0", resp_log.size() - r0, ack_log.size() - a0, busy);
    end
    set_ops(2, 4'd3, 4'd5);
    exp_q.push_back('{4'b0100, 8'd15, 1'b0});
    req_valid = 4'b0100;
    for (int c = 0; c < 60 && resp_log.size() < r0 + 1; c++) begin
      @(negedge clk);
      inj_ready = req_ack[2];
      req_valid = req_valid & ~req_ack;
    end
    inj_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (resp_log.size() - r0 != 1 || ack_log.size() - a0 != 1) begin
      tests_failed++;
      $display("FAIL start_ready_counts got resps=%0d acks=%0d, want 1/1", resp_log.size() - r0, ack_log.size() - a0);
    end else begin
      tests_run++;
      e = exp_q.pop_front();
      if ({resp_log[r0].vld, resp_log[r0].prod, resp_log[r0].err} !== {e.vld, e.prod, e.err}
          || resp_log[r0].cyc - ack_log[a0].cyc != N + 3) begin
        tests_failed++;
        $display("FAIL start_ready_resp got vld=%b prod=%0d err=%b lat=%0d, want vld=%b prod=%0d err=%b lat=%0d",
                 resp_log[r0].vld, resp_log[r0].prod, resp_log[r0].err, resp_log[r0].cyc - ack_log[a0].cyc,
                 e.vld, e.prod, e.err, N + 3);
      end
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_all_four();
    test_single();
    test_fairness();
    test_timeout();
    test_reset_mid_wait();
    test_ready_outside_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
